// File: rtl/sram_like_mem_slave.sv
// Memory-side responder for the sram-like bus: word array, fixed response latency, in-order queue.
// Optional random back-pressure via SRAM_SLAVE_RANDOM_STALL_EN (16-bit LFSR gates mem_addr_ok).
module sram_like_mem_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_addr_ok,
    output logic        mem_data_ok
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic [31:0]           mem_array [0:(1<<ADDR_WIDTH)-1];

    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [OCC_W-1:0]      occ_reg;

    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [FIFO_DEPTH-1:0] slot_wr;
    logic [ADDR_WIDTH-1:0] slot_idx [FIFO_DEPTH];
    logic [3:0]            slot_cd  [FIFO_DEPTH];

    logic                  full;
    logic                  stall_ok;
    logic                  enq;
    logic                  deq;
    logic [3:0]            wr_be;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

`ifdef SRAM_SLAVE_RANDOM_STALL_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign stall_ok = lfsr_reg[0];
`else
    assign stall_ok = 1'b1;
`endif

    // Occupancy before this cycle's pop: a full queue refuses even while the head completes.
    assign full        = (occ_reg == OCC_W'(FIFO_DEPTH));
    assign mem_addr_ok = rst & mem_req & ~full & stall_ok;
    assign enq         = mem_req & mem_addr_ok;
    assign deq         = slot_valid[head_reg] & (slot_cd[head_reg] == 4'd0);
    assign mem_data_ok = deq;
    assign mem_rdata   = (deq && !slot_wr[head_reg]) ? mem_array[slot_idx[head_reg]] : 32'd0;
    assign wr_idx      = mem_addr[ADDR_WIDTH+1:2];

    // Misaligned halves and words leave every lane disabled.
    always_comb begin
        wr_be = 4'b0000;
        case (mem_size)
            2'd0:    wr_be = 4'b0001 << mem_addr[1:0];
            2'd1:    wr_be = mem_addr[0] ? 4'b0000 : (mem_addr[1] ? 4'b1100 : 4'b0011);
            default: wr_be = (mem_addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq && mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_array[wr_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (enq) begin
                tail_reg <= (tail_reg == PTR_LAST) ? '0 : tail_reg + PTR_W'(1);
            end
            if (deq) begin
                head_reg <= (head_reg == PTR_LAST) ? '0 : head_reg + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Each slot counts down on its own; a slot at zero simply waits until it is the head.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic                  valid_reg;
            logic                  wr_reg;
            logic [ADDR_WIDTH-1:0] idx_reg;
            logic [3:0]            cd_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= 1'b0;
                    wr_reg    <= 1'b0;
                    idx_reg   <= '0;
                    cd_reg    <= 4'd0;
                end else if (enq && tail_reg == PTR_W'(gi)) begin
                    valid_reg <= 1'b1;
                    wr_reg    <= mem_wr;
                    idx_reg   <= wr_idx;
                    cd_reg    <= CD_INIT;
                end else if (deq && head_reg == PTR_W'(gi)) begin
                    valid_reg <= 1'b0;
                    cd_reg    <= 4'd0;
                end else if (cd_reg != 4'd0) begin
                    cd_reg <= cd_reg - 4'd1;
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_wr[gi]    = wr_reg;
            assign slot_idx[gi]   = idx_reg;
            assign slot_cd[gi]    = cd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: directed steps plus random traffic against a queue-based reference model.
module tb_sram_like_mem_slave;

    localparam int LAT = 2;
    localparam int DEP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_wr = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;

    sram_like_mem_slave #(.ADDR_WIDTH(10), .LATENCY(LAT), .FIFO_DEPTH(DEP)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok)
    );

    always #5 clk = ~clk;

    // Outstanding request: edge count at which it becomes due, kind, word index.
    typedef struct {
        int ready;
        bit wr;
        int idx;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mdl_mem [16];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          acc_cyc = 0;
    int          dok_cyc = -1;
    int          dok_seen = 0;
    int          acc_count = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int w = int'(addr[5:2]);
        int off = int'(addr[1:0]);
        bit en [4];
        for (int l = 0; l < 4; l++) en[l] = 1'b0;
        if (size == 2'd0) begin
            en[off] = 1'b1;
        end else if (size == 2'd1) begin
            if (off == 0 || off == 2) begin
                en[off] = 1'b1;
                en[off+1] = 1'b1;
            end
        end else if (off == 0) begin
            for (int l = 0; l < 4; l++) en[l] = 1'b1;
        end
        for (int l = 0; l < 4; l++)
            if (en[l]) mdl_mem[w][8*l +: 8] = wdata[8*l +: 8];
    endfunction

    task automatic step(input logic req, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, output logic acc);
        logic        exp_aok;
        logic        exp_dok;
        logic [31:0] exp_rd;
        mem_req   = req;
        mem_wr    = wr;
        mem_size  = size;
        mem_addr  = addr;
        mem_wdata = wdata;
        if (!rst) q.delete();
        #4;
        exp_aok = rst && req && (q.size() < DEP);
        exp_dok = rst && (q.size() > 0) && (cyc >= q[0].ready);
        exp_rd  = (exp_dok && !q[0].wr) ? mdl_mem[q[0].idx] : 32'd0;
        check("addr_ok", 32'(mem_addr_ok), 32'(exp_aok));
        check("data_ok", 32'(mem_data_ok), 32'(exp_dok));
        check("rdata", mem_rdata, exp_rd);
        if (mem_data_ok) begin
            dok_cyc = cyc;
            dok_seen++;
            last_rd = mem_rdata;
        end
        @(posedge clk);
        if (exp_dok) void'(q.pop_front());
        if (exp_aok) begin
            if (wr) mdl_write(size, addr, wdata);
            q.push_back('{ready: cyc + LAT, wr: wr, idx: int'(addr[5:2])});
        end
        cyc++;
        #1;
        acc = exp_aok;
    endtask

    task automatic send(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        logic acc;
        int   n = 0;
        do begin
            step(1'b1, wr, size, addr, wdata, acc);
            n++;
        end while (!acc && n < 20);
        check("send_accepted", 32'(acc), 32'd1);
        acc_cyc = cyc;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, acc);
    endtask

    initial begin
        logic acc;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
        @(posedge clk);
        #1;

        // Reset held with a live request
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 32'h10, 32'd0, acc);
        rst = 1'b1;
        step(1'b1, 1'b1, 2'd2, 32'h0, 32'h0, acc);
        check("release_accept", 32'(acc), 32'd1);
        for (int i = 1; i < 16; i++) send(1'b1, 2'd2, 32'(4 * i), 32'd0);
        idle(4);

        // Word write then read, latency from acceptance
        dok_cyc = -1;
        send(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        idle(3);
        check("lat_wr", 32'(dok_cyc - acc_cyc), 32'(LAT - 1));
        dok_cyc = -1;
        send(1'b0, 2'd2, 32'h10, 32'd0);
        idle(3);
        check("lat_rd", 32'(dok_cyc - acc_cyc), 32'(LAT - 1));
        check("rd_deadbeef", last_rd, 32'hDEADBEEF);

        // Byte and half lanes
        send(1'b1, 2'd2, 32'h10, 32'h0);
        send(1'b1, 2'd0, 32'h11, 32'h0000AA00);
        send(1'b1, 2'd1, 32'h12, 32'h55660000);
        send(1'b0, 2'd0, 32'h13, 32'd0);
        idle(3);
        check("rd_lanes", last_rd, 32'h5566AA00);

        // Misaligned half: responds, leaves memory alone
        dok_cyc = -1;
        send(1'b1, 2'd1, 32'h21, 32'hFFFFFFFF);
        idle(3);
        check("misal_dok", 32'(dok_cyc - acc_cyc), 32'(LAT - 1));
        send(1'b0, 2'd2, 32'h20, 32'd0);
        idle(3);
        check("misal_rd", last_rd, 32'd0);

        // Request held high from empty: no bypass on full
        acc_count = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'd2, 32'h10, 32'd0, acc);
            if (acc) acc_count++;
        end
        check("full_refuse", 32'(acc_count), 32'd3);
        idle(4);

        // Reset with two reads outstanding
        send(1'b1, 2'd2, 32'h30, 32'h12345678);
        idle(3);
        send(1'b0, 2'd2, 32'h10, 32'd0);
        send(1'b0, 2'd2, 32'h20, 32'd0);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        dok_seen = 0;
        idle(5);
        check("no_dok_after_rst", 32'(dok_seen), 32'd0);
        send(1'b0, 2'd2, 32'h30, 32'd0);
        idle(3);
        check("wr_survives_rst", last_rd, 32'h12345678);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 32'hFFFFF), 6'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            rst = ($urandom_range(0, 63) != 0);
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, acc);
        end
        rst = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
